// File: rtl/mux_ctrl_rd_pkg.sv
// Shared constants and types for the per-output read/mux controller.
// PORT_NUB_TOTAL : default number of output ports / source queues
// DATA_WIDTH     : datapath word width (used by the external data mux)
// PKT_LEN_WIDTH  : packet length field width (length-minus-one, in words)
package mux_ctrl_rd_pkg;

  localparam int unsigned PORT_NUB_TOTAL = 4;
  localparam int unsigned DATA_WIDTH     = 32;
  localparam int unsigned PKT_LEN_WIDTH  = 8;

  // Per-output transfer state
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } xfer_state_e;

  // Round-robin successor of idx in a ring of n entries
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return ((idx + 1) >= n) ? 0 : (idx + 1);
  endfunction

endpackage

// File: rtl/rd_rr_arb.sv
// Combinational round-robin picker: first set bit of eligible_i searching
// upward from ptr_i and wrapping.
// eligible_i : candidate sources
// ptr_i      : search start index
// winner_c   : index of the selected source (0 when none)
// found_c    : at least one candidate was eligible
module rd_rr_arb #(
  parameter  int unsigned N    = 4,
  localparam int unsigned SELW = $clog2(N)
) (
  input  logic [N-1:0]    eligible_i,
  input  logic [SELW-1:0] ptr_i,
  output logic [SELW-1:0] winner_c,
  output logic            found_c
);

  // Rotating priority search
  always_comb begin : rr_search
    int unsigned idx;
    idx      = 0;
    winner_c = '0;
    found_c  = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr_i) + k) % N;
      if (!found_c && eligible_i[idx]) begin
        found_c  = 1'b1;
        winner_c = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_ctrl_rd.sv
// Control plane for an N-output packet switch read side. One FSM per output
// grants a source queue round-robin, counts the packet words out and pops the
// granted source on every accepted word. The data mux lives outside.
// clk, rst   : clock, synchronous active-high reset
// src_req    : bit i*N+j -> source j's head packet targets output i
// src_len    : slice j = source j's head packet length minus one
// out_rdy    : output i accepts a word this cycle
// out_vld    : output i is presenting a word
// mux_sel    : slice i = source index granted to output i
// rd_en_out  : pop one word from source j
// pkt_done   : output i is transferring the last word of its packet
module mux_ctrl_rd
  import mux_ctrl_rd_pkg::*;
#(
  parameter  int unsigned PORT_NUB  = PORT_NUB_TOTAL,
  parameter  int unsigned LEN_WIDTH = PKT_LEN_WIDTH,
  localparam int unsigned WIDTH_SEL = $clog2(PORT_NUB)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PORT_NUB*PORT_NUB-1:0]    src_req,
  input  logic [PORT_NUB*LEN_WIDTH-1:0]   src_len,
  input  logic [PORT_NUB-1:0]             out_rdy,
  output logic [PORT_NUB-1:0]             out_vld,
  output logic [PORT_NUB*WIDTH_SEL-1:0]   mux_sel,
  output logic [PORT_NUB-1:0]             rd_en_out,
  output logic [PORT_NUB-1:0]             pkt_done
);

  logic [PORT_NUB-1:0]                xfer_c;
  logic [PORT_NUB-1:0][WIDTH_SEL-1:0] sel_all_c;
  logic [PORT_NUB-1:0]                busy_c;

  // Sources currently owned by an output in XFER
  always_comb begin : busy_logic
    busy_c = '0;
    for (int unsigned i = 0; i < PORT_NUB; i++) begin
      for (int unsigned j = 0; j < PORT_NUB; j++) begin
        if (xfer_c[i] && (sel_all_c[i] == WIDTH_SEL'(j))) busy_c[j] = 1'b1;
      end
    end
  end

  // Pop strobes; suppressed during reset so an aborted packet loses no words
  always_comb begin : pop_logic
    rd_en_out = '0;
    for (int unsigned i = 0; i < PORT_NUB; i++) begin
      for (int unsigned j = 0; j < PORT_NUB; j++) begin
        if (xfer_c[i] && out_rdy[i] && (sel_all_c[i] == WIDTH_SEL'(j)) && !rst)
          rd_en_out[j] = 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < PORT_NUB; gi++) begin : g_out
    xfer_state_e          state_q, state_d;
    logic [WIDTH_SEL-1:0] sel_q, sel_d;
    logic [WIDTH_SEL-1:0] ptr_q, ptr_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH_SEL-1:0] win_c;
    logic                 found_c;
    logic [LEN_WIDTH-1:0] len_win_c;
    logic [PORT_NUB-1:0]  claim_in_c, claim_out_c, elig_c;

    // Sources taken this cycle by lower-indexed idle outputs
    if (gi == 0) begin : g_head
      assign claim_in_c = '0;
    end else begin : g_link
      assign claim_in_c = g_out[gi-1].claim_out_c;
    end

    assign elig_c = (state_q == ST_IDLE)
                  ? (src_req[gi*PORT_NUB +: PORT_NUB] & ~busy_c & ~claim_in_c)
                  : '0;

    rd_rr_arb #(
      .N (PORT_NUB)
    ) u_arb (
      .eligible_i (elig_c),
      .ptr_i      (ptr_q),
      .winner_c   (win_c),
      .found_c    (found_c)
    );

    assign claim_out_c = claim_in_c | (found_c ? (PORT_NUB'(1) << win_c) : '0);

    // Length of the winning source's head packet
    always_comb begin : len_pick
      len_win_c = '0;
      for (int unsigned j = 0; j < PORT_NUB; j++) begin
        if (win_c == WIDTH_SEL'(j)) len_win_c = src_len[j*LEN_WIDTH +: LEN_WIDTH];
      end
    end

    // Next-state logic
    always_comb begin : fsm_next
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      case (state_q)
        ST_IDLE: begin
          if (found_c) begin
            sel_d   = win_c;
            cnt_d   = len_win_c;
            state_d = ST_XFER;
          end
        end
        ST_XFER: begin
          if (out_rdy[gi]) begin
            if (cnt_q == '0) begin
              state_d = ST_IDLE;
              ptr_d   = WIDTH_SEL'(rr_next(32'(sel_q), PORT_NUB));
            end else begin
              cnt_d = cnt_q - LEN_WIDTH'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // State register
    always_ff @(posedge clk) begin : fsm_reg
      if (rst) begin
        state_q <= ST_IDLE;
        sel_q   <= '0;
        ptr_q   <= '0;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        sel_q   <= sel_d;
        ptr_q   <= ptr_d;
        cnt_q   <= cnt_d;
      end
    end

    assign xfer_c[gi]    = (state_q == ST_XFER);
    assign sel_all_c[gi] = sel_q;
    assign out_vld[gi]   = xfer_c[gi];
    assign mux_sel[gi*WIDTH_SEL +: WIDTH_SEL] = sel_q;
    assign pkt_done[gi]  = xfer_c[gi] && out_rdy[gi] && (cnt_q == '0) && !rst;
  end

endmodule

// File: tb/tb_mux_ctrl_rd.sv
// Directed bench for mux_ctrl_rd with N=4, LEN_WIDTH=8.
module tb_mux_ctrl_rd;

  localparam int unsigned N  = 4;
  localparam int unsigned LW = 8;
  localparam int unsigned SW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*N-1:0]    src_req;
  logic [N*LW-1:0]   src_len;
  logic [N-1:0]      out_rdy;
  logic [N-1:0]      out_vld;
  logic [N*SW-1:0]   mux_sel;
  logic [N-1:0]      rd_en_out;
  logic [N-1:0]      pkt_done;

  int n_cmp = 0;
  int n_err = 0;

  mux_ctrl_rd #(
    .PORT_NUB  (N),
    .LEN_WIDTH (LW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .src_req   (src_req),
    .src_len   (src_len),
    .out_rdy   (out_rdy),
    .out_vld   (out_vld),
    .mux_sel   (mux_sel),
    .rd_en_out (rd_en_out),
    .pkt_done  (pkt_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; src_req = '0; src_len = '0; out_rdy = '1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; src_req = '0; src_len = '0; out_rdy = '1;
    tick(); tick(); settle();
    n_cmp++;
    if ({out_vld, rd_en_out, pkt_done} !== 12'h000) begin
      n_err++; $display("FAIL reset_outs: got vld=%b rd=%b done=%b, want all 0", out_vld, rd_en_out, pkt_done);
    end
    n_cmp++;
    if (mux_sel !== 8'h00) begin
      n_err++; $display("FAIL reset_sel: got %h want 00", mux_sel);
    end
    src_req = 16'h0040; src_len[2*LW +: LW] = 8'd3;
    tick(); settle();
    n_cmp++;
    if (out_vld !== 4'b0000 || rd_en_out !== 4'b0000) begin
      n_err++; $display("FAIL reset_hold: got vld=%b rd=%b want 0000/0000", out_vld, rd_en_out);
    end
    src_req = '0; rst = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    src_len[2*LW +: LW] = 8'd3; src_req = 16'h0040; settle();
    n_cmp++;
    if (out_vld !== 4'b0000) begin
      n_err++; $display("FAIL basic_idle: got vld=%b want 0000", out_vld);
    end
    for (int k = 0; k < 4; k++) begin
      tick(); src_req = '0; settle();
      n_cmp++;
      if (out_vld !== 4'b0010 || rd_en_out !== 4'b0100 || mux_sel[3:2] !== 2'd2 ||
          pkt_done !== ((k == 3) ? 4'b0010 : 4'b0000)) begin
        n_err++;
        $display("FAIL basic_word%0d: got vld=%b rd=%b sel1=%0d done=%b want 0010/0100/2/%b",
                 k, out_vld, rd_en_out, mux_sel[3:2], pkt_done, (k == 3) ? 4'b0010 : 4'b0000);
      end
    end
    tick(); settle();
    n_cmp++;
    if (out_vld !== 4'b0000 || rd_en_out !== 4'b0000 || mux_sel[3:2] !== 2'd2) begin
      n_err++; $display("FAIL basic_after: got vld=%b rd=%b sel1=%0d want 0000/0000/2", out_vld, rd_en_out, mux_sel[3:2]);
    end
    // ptr[1] should now be 3: sources 0 and 3 both request output 1
    src_len[0 +: LW] = 8'd0; src_len[3*LW +: LW] = 8'd0; src_req = 16'h0090;
    tick(); src_req = '0; settle();
    n_cmp++;
    if (mux_sel[3:2] !== 2'd3 || rd_en_out !== 4'b1000 || pkt_done !== 4'b0010) begin
      n_err++; $display("FAIL basic_ptr: got sel1=%0d rd=%b done=%b want 3/1000/0010", mux_sel[3:2], rd_en_out, pkt_done);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    src_len[0 +: LW] = 8'd0; src_len[3*LW +: LW] = 8'd0; src_req = 16'h0009;
    tick(); src_req = 16'h0008; settle();
    n_cmp++;
    if (out_vld !== 4'b0001 || mux_sel[1:0] !== 2'd0 || rd_en_out !== 4'b0001 || pkt_done !== 4'b0001) begin
      n_err++; $display("FAIL rr_first: got vld=%b sel0=%0d rd=%b done=%b want 0001/0/0001/0001", out_vld, mux_sel[1:0], rd_en_out, pkt_done);
    end
    tick(); settle();
    n_cmp++;
    if (out_vld !== 4'b0000 || rd_en_out !== 4'b0000 || pkt_done !== 4'b0000) begin
      n_err++; $display("FAIL rr_bubble: got vld=%b rd=%b done=%b want 0000/0000/0000", out_vld, rd_en_out, pkt_done);
    end
    tick(); src_req = '0; settle();
    n_cmp++;
    if (out_vld !== 4'b0001 || mux_sel[1:0] !== 2'd3 || rd_en_out !== 4'b1000 || pkt_done !== 4'b0001) begin
      n_err++; $display("FAIL rr_second: got vld=%b sel0=%0d rd=%b done=%b want 0001/3/1000/0001", out_vld, mux_sel[1:0], rd_en_out, pkt_done);
    end
    tick(); src_req = 16'h0009; settle();
    tick(); src_req = '0; settle();
    n_cmp++;
    if (mux_sel[1:0] !== 2'd0 || rd_en_out !== 4'b0001) begin
      n_err++; $display("FAIL rr_wrap: got sel0=%0d rd=%b want 0/0001", mux_sel[1:0], rd_en_out);
    end
  endtask

  task automatic test_backpressure();
    bit rdy_seq [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int pops = 0;
    do_reset();
    src_len[0 +: LW] = 8'd2; src_req = 16'h0010;
    for (int k = 0; k < 5; k++) begin
      tick(); src_req = '0;
      out_rdy = rdy_seq[k] ? 4'b1111 : 4'b1101;
      settle();
      n_cmp++;
      if (out_vld[1] !== 1'b1 || rd_en_out[0] !== rdy_seq[k] || pkt_done[1] !== (k == 4)) begin
        n_err++; $display("FAIL bp_cycle%0d: got vld1=%b rd0=%b done1=%b want 1/%b/%b", k, out_vld[1], rd_en_out[0], pkt_done[1], rdy_seq[k], (k == 4));
      end
      if (rd_en_out[0] === 1'b1) pops++;
    end
    n_cmp++;
    if (pops != 3) begin
      n_err++; $display("FAIL bp_pops: got %0d want 3", pops);
    end
    tick(); out_rdy = '1; settle();
    n_cmp++;
    if (out_vld !== 4'b0000) begin
      n_err++; $display("FAIL bp_end: got vld=%b want 0000", out_vld);
    end
  endtask

  task automatic test_busy();
    do_reset();
    src_len[2*LW +: LW] = 8'd1; src_req = 16'h0004;
    // source 2 now asks for output 1 and changes its length; output 0 ignores both
    tick(); src_req = 16'h0040; src_len[2*LW +: LW] = 8'd0; settle();
    n_cmp++;
    if (out_vld !== 4'b0001 || mux_sel[1:0] !== 2'd2 || rd_en_out !== 4'b0100 || pkt_done !== 4'b0000) begin
      n_err++; $display("FAIL busy_w0: got vld=%b sel0=%0d rd=%b done=%b want 0001/2/0100/0000", out_vld, mux_sel[1:0], rd_en_out, pkt_done);
    end
    tick(); settle();
    n_cmp++;
    if (out_vld !== 4'b0001 || pkt_done !== 4'b0001) begin
      n_err++; $display("FAIL busy_w1: got vld=%b done=%b want 0001/0001", out_vld, pkt_done);
    end
    tick(); settle();
    n_cmp++;
    if (out_vld !== 4'b0000) begin
      n_err++; $display("FAIL busy_gap: got vld=%b want 0000", out_vld);
    end
    tick(); src_req = '0; settle();
    n_cmp++;
    if (out_vld !== 4'b0010 || mux_sel[3:2] !== 2'd2 || rd_en_out !== 4'b0100 || pkt_done !== 4'b0010) begin
      n_err++; $display("FAIL busy_grant1: got vld=%b sel1=%0d rd=%b done=%b want 0010/2/0100/0010", out_vld, mux_sel[3:2], rd_en_out, pkt_done);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    src_len[1*LW +: LW] = 8'd0; src_req = 16'h2002;
    tick(); src_req = '0; settle();
    n_cmp++;
    if (out_vld !== 4'b0001 || mux_sel[1:0] !== 2'd1 || rd_en_out !== 4'b0010 || pkt_done !== 4'b0001) begin
      n_err++; $display("FAIL conflict: got vld=%b sel0=%0d rd=%b done=%b want 0001/1/0010/0001", out_vld, mux_sel[1:0], rd_en_out, pkt_done);
    end
    tick(); settle();
    n_cmp++;
    if (out_vld !== 4'b0000) begin
      n_err++; $display("FAIL conflict_after: got vld=%b want 0000", out_vld);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    src_len[3*LW +: LW] = 8'd4; src_req = 16'h0800;
    tick(); src_req = '0; settle();
    n_cmp++;
    if (out_vld !== 4'b0100 || rd_en_out !== 4'b1000 || mux_sel[5:4] !== 2'd3) begin
      n_err++; $display("FAIL rstmid_w0: got vld=%b rd=%b sel2=%0d want 0100/1000/3", out_vld, rd_en_out, mux_sel[5:4]);
    end
    tick(); rst = 1'b1; settle();
    n_cmp++;
    if (rd_en_out !== 4'b0000 || pkt_done !== 4'b0000) begin
      n_err++; $display("FAIL rstmid_during: got rd=%b done=%b want 0000/0000", rd_en_out, pkt_done);
    end
    tick(); rst = 1'b0; settle();
    n_cmp++;
    if ({out_vld, rd_en_out, pkt_done} !== 12'h000 || mux_sel !== 8'h00) begin
      n_err++; $display("FAIL rstmid_after: got vld=%b rd=%b done=%b sel=%h want all 0", out_vld, rd_en_out, pkt_done, mux_sel);
    end
    for (int k = 0; k < 3; k++) begin
      tick(); settle();
      n_cmp++;
      if (rd_en_out !== 4'b0000 || out_vld !== 4'b0000) begin
        n_err++; $display("FAIL rstmid_quiet%0d: got vld=%b rd=%b want 0000/0000", k, out_vld, rd_en_out);
      end
    end
  endtask

  initial begin
    rst = 1'b1; src_req = '0; src_len = '0; out_rdy = '1;
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_busy();
    test_conflict();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mux_ctrl_rd.md
MUX_CTRL_RD -- requirements
Module: mux_ctrl_rd

Interface
REQ-001 SHALL have parameter PORT_NUB, default `PORT_NUB_TOTAL: number of output ports and of source queues (N).
REQ-002 SHALL have parameter LEN_WIDTH, default `PKT_LEN_WIDTH (8): packet length field width.
REQ-003 SHALL derive localparam WIDTH_SEL = $clog2(PORT_NUB).
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 SHALL have port clk, input, 1 bit: single clock, all logic on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-007 SHALL have port src_req, input, N*N bits: bit i*N+j set when source j's head packet targets output i.
REQ-008 SHALL have port src_len, input, N*LEN_WIDTH bits: slice j is source j's head packet length minus 1, in words.
REQ-009 SHALL have port out_rdy, input, N bits: output port i accepts a word.
REQ-010 SHALL have port out_vld, output, N bits: output i is presenting a word.
REQ-011 SHALL have port mux_sel, output, N*WIDTH_SEL bits: slice i is the source index granted to output i.
REQ-012 SHALL have port rd_en_out, output, N bits: pop one word from source j.
REQ-013 SHALL have port pkt_done, output, N bits: one-cycle pulse on the last word of output i's packet.

Function
REQ-014 SHALL run one independent FSM per output i, with states IDLE and XFER.
REQ-015 In IDLE, the FSM SHALL form eligible = row i of src_req AND NOT busy, where busy[j] = source j is granted by any output in XFER.
REQ-016 If eligible is nonzero in IDLE, the FSM SHALL register a round-robin winner (search from ptr[i] upward, wrapping) into mux_sel[i].
REQ-017 In the same IDLE case, the FSM SHALL load cnt[i] with src_len of the winner and move to XFER; latency is 1 cycle from request to out_vld.
REQ-018 If eligible is zero in IDLE, the FSM SHALL hold state and ptr.
REQ-019 out_vld[i] SHALL be 1 exactly when FSM i is in XFER (registered).
REQ-020 A word SHALL transfer when out_vld[i] AND out_rdy[i]; rd_en_out[j] SHALL be the OR over i of (XFER_i AND mux_sel[i]==j AND out_rdy[i]).
REQ-021 On each transfer with cnt[i] != 0, cnt[i] SHALL decrement.
REQ-022 On a transfer with cnt[i] == 0, the FSM SHALL assert pkt_done[i] combinationally, return to IDLE, and set ptr[i] = winner+1 mod N.
REQ-023 With out_rdy[i]=0, state, cnt, and mux_sel SHALL hold; no pop SHALL occur.
REQ-024 Return to IDLE SHALL cost one bubble cycle; a re-grant is possible in the cycle after pkt_done.
REQ-025 If two IDLE outputs pick the same source in one cycle (src_req violation), the lowest-index output SHALL win; higher outputs SHALL treat that source as busy.
REQ-026 src_len = 0 SHALL mean a single-word packet: pkt_done on the first transfer.
REQ-027 src_req/src_len SHALL be sampled only in IDLE; changes during XFER SHALL be ignored.
REQ-028 mux_sel[i] SHALL be held after pkt_done until the next grant.

Reset
REQ-029 On rst, all FSMs SHALL go to IDLE; out_vld, rd_en_out, and pkt_done SHALL be 0; mux_sel, cnt, and ptr SHALL be 0.
REQ-030 Reset mid-XFER SHALL abort the packet with no further pops; recovery is the source's responsibility.

Structure
REQ-031 PORT_NUB_TOTAL, DATA_WIDTH, and the new PKT_LEN_WIDTH SHALL live in the shared generate_parameter.vh.
REQ-032 The round-robin search SHALL be one combinational sub-module, rd_rr_arb (inputs: eligible, ptr; outputs: winner index, found), instanced per output.
REQ-033 The datapath mux SHALL be outside this block; this block is control only.

Verification (N=4)
REQ-034 After reset, src_req bit 1*4+2 set, src_len[2]=3, out_rdy=1111 -> out_vld[1] next cycle, mux_sel[1]=2, rd_en_out[2] for 4 cycles, pkt_done[1] on the 4th, ptr[1]=3.
REQ-035 Sources 0 and 3 both request output 0 with len 0, ptr=0 -> source 0 granted first; after the bubble, source 3; then ptr=0.
REQ-036 out_rdy[1] toggles 1,0,0,1,1 on a len-2 packet -> exactly 3 pops, none on rdy=0 cycles, pkt_done on the 5th cycle.
REQ-037 Source 2 is busy on output 0 while requesting output 1 -> output 1 stays IDLE until cycle after pkt_done[0], then grants 2.
REQ-038 src_req sets source 1 for outputs 0 and 3 simultaneously -> only output 0 grants; output 3 remains IDLE.
REQ-039 Assert rst during word 2 of 5 -> next cycle all outputs 0, no rd_en_out thereafter.
